qgpio_bank: RTL and testbench

- Parametrised GPIO bank RTL; successor to the fixed-width QGPIO signal model.
- Per-pin direction and output value, synchronised and debounced inputs, and per-pin rising/falling edge interrupts with sticky write-1-to-clear status.
- Register access is a simple single-cycle req/ack bus in DATA_W-bit words.
- Pin count is any value 1..200; registers are split into NW = ceil(NUM_PINS/DATA_W) words.

---
 rtl/qgpio_bank_if.sv | 17 +
 rtl/qgpio_bank.sv | 158 +++++++++++++++
 tb/tb_qgpio_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/qgpio_bank_if.sv
// Register bus for qgpio_bank: single-cycle req/ack access in DATA_W-bit words.
// A request is acked exactly once, in order, with rdata/err valid alongside ack.
interface qgpio_bank_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
);
  logic              req;
  logic              we;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/qgpio_bank.sv
// Parametrised GPIO bank: direction/output registers, synchronised and debounced
// inputs, per-pin rise/fall interrupt status with write-1-to-clear.
module qgpio_bank #(
  parameter int NUM_PINS    = 64,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  qgpio_bank_if.slave         bus,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

  localparam int NW     = (NUM_PINS + DATA_W - 1) / DATA_W;
  localparam int WIDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW     = NW * DATA_W;

  logic                vld_p0;
  logic                we_p0;
  logic [2:0]          grp_p0;
  logic [WIDX_W-1:0]   widx_p0;
  logic [DATA_W-1:0]   wdata_p0;

  logic                ack_p1;
  logic                err_p1;
  logic [DATA_W-1:0]   rdata_p1;

  logic [NUM_PINS-1:0] dir_r, out_r, rise_en, fall_en, stat;
  logic [DEB_W-1:0]    deb_d;

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_r;
  logic [NUM_PINS-1:0] s_in, stable, upd, stat_set, stat_clr;
  logic [DEB_W-1:0]    cnt [NUM_PINS];

  logic                bad_p0, wr_ok;
  logic [DATA_W-1:0]   rd_word;

  function automatic logic [DATA_W-1:0] word_of(input logic [NUM_PINS-1:0] v,
                                                input logic [WIDX_W-1:0]   w);
    logic [PW-1:0] pad;
    pad = '0;
    pad[NUM_PINS-1:0] = v;
    word_of = '0;
    for (int i = 0; i < NW; i++)
      if (int'(w) == i) word_of = pad[i*DATA_W +: DATA_W];
  endfunction

  // Replace the pins of word w with d; pins past NUM_PINS simply do not exist.
  function automatic logic [NUM_PINS-1:0] merge_word(input logic [NUM_PINS-1:0] v,
                                                     input logic [WIDX_W-1:0]   w,
                                                     input logic [DATA_W-1:0]   d);
    merge_word = v;
    for (int i = 0; i < NUM_PINS; i++)
      if (int'(w) == i / DATA_W) merge_word[i] = d[i % DATA_W];
  endfunction

  // Stage p0: capture the request
  always_ff @(posedge clk) begin
    we_p0    <= bus.we;
    grp_p0   <= bus.addr[WIDX_W+2:WIDX_W];
    widx_p0  <= bus.addr[WIDX_W-1:0];
    wdata_p0 <= bus.wdata;
  end

  always_comb begin
    bad_p0 = (int'(widx_p0) >= NW) || (grp_p0 == 3'd7) ||
             ((grp_p0 == 3'd6) && (widx_p0 != '0));
    wr_ok  = vld_p0 && we_p0 && !bad_p0;
    rd_word = '0;
    case (grp_p0)
      3'd0:    rd_word = word_of(dir_r, widx_p0);
      3'd1:    rd_word = word_of(out_r, widx_p0);
      3'd2:    rd_word = word_of(stable, widx_p0);
      3'd3:    rd_word = word_of(rise_en, widx_p0);
      3'd4:    rd_word = word_of(fall_en, widx_p0);
      3'd5:    rd_word = word_of(stat, widx_p0);
      3'd6:    rd_word[DEB_W-1:0] = deb_d;
      default: rd_word = '0;
    endcase
    if (bad_p0) rd_word = '0;
    stat_clr = '0;
    if (wr_ok && grp_p0 == 3'd5) stat_clr = merge_word('0, widx_p0, wdata_p0);
  end

  // Stage p1: ack, read data, register writes and status update
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      ack_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
      dir_r    <= '0;
      out_r    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      stat     <= '0;
      deb_d    <= '0;
    end else begin
      vld_p0   <= bus.req;
      ack_p1   <= vld_p0;
      err_p1   <= vld_p0 && bad_p0;
      rdata_p1 <= vld_p0 ? rd_word : '0;
      if (wr_ok) begin
        case (grp_p0)
          3'd0:    dir_r   <= merge_word(dir_r, widx_p0, wdata_p0);
          3'd1:    out_r   <= merge_word(out_r, widx_p0, wdata_p0);
          3'd3:    rise_en <= merge_word(rise_en, widx_p0, wdata_p0);
          3'd4:    fall_en <= merge_word(fall_en, widx_p0, wdata_p0);
          3'd6:    deb_d   <= wdata_p0[DEB_W-1:0];
          default: ;
        endcase
      end
      // A new event outranks a simultaneous clear of the same bit.
      stat <= (stat & ~stat_clr) | stat_set;
    end
  end

  assign s_in = sync_r[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < NUM_PINS; i++)
      upd[i] = (s_in[i] != stable[i]) && (cnt[i] == deb_d);
    stat_set = (upd & s_in & rise_en) | (upd & ~s_in & fall_en);
  end

  // Input path: synchroniser then per-pin debounce counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_PINS; i++) cnt[i] <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
      for (int i = 0; i < NUM_PINS; i++) begin
        if (s_in[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == deb_d) begin
          stable[i] <= s_in[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.ack   = ack_p1;
  assign bus.err   = err_p1;
  assign bus.rdata = rdata_p1;
  assign pin_oe    = dir_r;
  assign pin_out   = out_r;
  assign irq       = |stat;

endmodule

// File: tb/tb_qgpio_bank.sv
// Bench for qgpio_bank: directed register/pin stimulus, with bus responses
// checked by a scoreboard monitor decoupled from the driver.
module tb_qgpio_bank;
  localparam int NP = 40;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qgpio_bank_if #(.DATA_W(DW), .AW(AW)) bus ();
  logic [NP-1:0] pin_in, pin_out, pin_oe;
  logic          irq;

  qgpio_bank #(.NUM_PINS(NP), .DATA_W(DW), .SYNC_STAGES(2), .DEB_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq));

  // Second instance with 16-bit words gives three words, so an out-of-range word index exists.
  qgpio_bank_if #(.DATA_W(16), .AW(5)) bus2 ();
  logic [NP-1:0] pin_in2, pin_out2, pin_oe2;
  logic          irq2;

  qgpio_bank #(.NUM_PINS(NP), .DATA_W(16), .SYNC_STAGES(2), .DEB_W(8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .pin_in(pin_in2), .pin_out(pin_out2), .pin_oe(pin_oe2), .irq(irq2));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    logic        consec;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  logic prev_ack = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got ack=1 rdata=%h expected no ack", bus.rdata);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_err"}, bus.err, mon_e.err);
        if (mon_e.chk_rd) chk({mon_e.name, "_rdata"}, bus.rdata, mon_e.rd);
        if (mon_e.consec) chk({mon_e.name, "_consec"}, prev_ack, 1);
      end
    end
    prev_ack = bus.ack;
  end

  task automatic issue(input logic w, input logic [2:0] g, input logic wi, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr, input logic chk_rd,
                       input logic consec, input string nm, input logic push);
    exp_t e;
    bus.req = 1'b1; bus.we = w; bus.addr = {g, wi}; bus.wdata = d;
    if (push) begin
      e.rd = erd; e.err = eerr; e.chk_rd = chk_rd; e.consec = consec; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] g, input logic wi, input logic [31:0] d, input string nm);
    issue(1'b1, g, wi, d, '0, 1'b0, 1'b0, 1'b0, nm, 1'b1);
    idle();
  endtask

  task automatic rd(input logic [2:0] g, input logic wi, input logic [31:0] erd,
                    input logic eerr, input string nm);
    issue(1'b0, g, wi, '0, erd, eerr, 1'b1, 1'b0, nm, 1'b1);
    idle();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic acc2(input logic w, input logic [2:0] g, input logic [1:0] wi,
                      input logic [15:0] d, input logic [15:0] erd, input logic eerr,
                      input string nm);
    bus2.req = 1'b1; bus2.we = w; bus2.addr = {g, wi}; bus2.wdata = d;
    @(posedge clk); #1;
    bus2.req = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ack"}, bus2.ack, 1);
    chk({nm, "_err"}, bus2.err, eerr);
    if (!w) chk({nm, "_rdata"}, bus2.rdata, erd);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    pin_in = '0; pin_in2 = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    chk("rst_pin_oe", pin_oe, 0);
    chk("rst_pin_out", pin_out, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);

    for (int g = 0; g < 8; g++)
      for (int w = 0; w < 2; w++)
        rd(3'(g), w[0], 32'h0, (g == 7) || (g == 6 && w == 1), $sformatf("rst_rd_g%0d_w%0d", g, w));

    // Direction and output registers drive the pins directly
    wr(3'd0, 1'b0, 32'hFFFF_0000, "wr_dir0");
    chk("pin_oe_w0", pin_oe[31:0], 32'hFFFF_0000);
    wr(3'd1, 1'b0, 32'h00FF_FF00, "wr_out0");
    chk("pin_out_w0", pin_out[31:0], 32'h00FF_FF00);
    wr(3'd0, 1'b1, 32'hFFFF_FFFF, "wr_dir1");
    rd(3'd0, 1'b1, 32'h0000_00FF, 1'b0, "rd_dir1");
    chk("pin_oe_all", pin_oe, 40'hFF_FFFF_0000);
    wr(3'd2, 1'b0, 32'hFFFF_FFFF, "wr_in_ro");
    rd(3'd2, 1'b0, 32'h0, 1'b0, "rd_in_ro");

    // D=0: rising edge on pin 0 reaches stable/STAT three edges after the change
    wr(3'd3, 1'b0, 32'h1, "wr_rise_en");
    pin_in[0] = 1'b1;
    cycles(2);
    chk("irq_before_3edges", irq, 0);
    cycles(1);
    chk("irq_after_3edges", irq, 1);
    rd(3'd2, 1'b0, 32'h1, 1'b0, "rd_in_bit0");
    rd(3'd5, 1'b0, 32'h1, 1'b0, "rd_stat_bit0");
    wr(3'd5, 1'b0, 32'h1, "w1c_bit0");
    chk("irq_after_clear", irq, 0);
    rd(3'd5, 1'b0, 32'h0, 1'b0, "rd_stat_cleared");

    // D=5: a 4-cycle glitch is filtered, a held level lands after 8 edges
    wr(3'd6, 1'b0, 32'h5, "wr_deb5");
    rd(3'd6, 1'b0, 32'h5, 1'b0, "rd_deb5");
    wr(3'd3, 1'b0, 32'h9, "wr_rise_en9");
    pin_in[3] = 1'b1;
    cycles(4);
    pin_in[3] = 1'b0;
    cycles(10);
    chk("irq_glitch", irq, 0);
    rd(3'd2, 1'b0, 32'h1, 1'b0, "rd_in_glitch");
    rd(3'd5, 1'b0, 32'h0, 1'b0, "rd_stat_glitch");
    pin_in[3] = 1'b1;
    cycles(7);
    chk("irq_deb_7edges", irq, 0);
    cycles(1);
    chk("irq_deb_8edges", irq, 1);
    rd(3'd2, 1'b0, 32'h9, 1'b0, "rd_in_bit3");
    rd(3'd5, 1'b0, 32'h8, 1'b0, "rd_stat_bit3");
    wr(3'd5, 1'b0, 32'h8, "w1c_bit3");
    chk("irq_clear3", irq, 0);

    // Falling edge on pin 1 coincides with a clear of the same bit: the event wins
    wr(3'd6, 1'b0, 32'h0, "wr_deb0");
    wr(3'd4, 1'b0, 32'h2, "wr_fall_en");
    pin_in[1] = 1'b1;
    cycles(5);
    chk("irq_rise_unenabled", irq, 0);
    pin_in[1] = 1'b0;
    cycles(1);
    issue(1'b1, 3'd5, 1'b0, 32'h2, '0, 1'b0, 1'b0, 1'b0, "w1c_collide", 1'b1);
    idle();
    chk("irq_set_wins", irq, 1);
    rd(3'd5, 1'b0, 32'h2, 1'b0, "rd_stat_set_wins");
    wr(3'd5, 1'b0, 32'h2, "w1c_bit1");
    chk("irq_clear1", irq, 0);

    // Back-to-back write then read
    issue(1'b1, 3'd1, 1'b0, 32'hA5, '0, 1'b0, 1'b0, 1'b0, "b2b_wr", 1'b1);
    issue(1'b0, 3'd1, 1'b0, '0, 32'hA5, 1'b0, 1'b1, 1'b1, "b2b_rd", 1'b1);
    idle();
    cycles(1);
    chk("pin_out_a5", pin_out[31:0], 32'hA5);

    // Reset while a write is in flight: no ack, no write
    issue(1'b1, 3'd1, 1'b0, 32'hFF, '0, 1'b0, 1'b0, 1'b0, "rst_wr", 1'b0);
    rst = 1'b1;
    bus.req = 1'b0;
    cycles(2);
    rst = 1'b0;
    chk("rst_mid_pin_out", pin_out, 0);
    chk("rst_mid_pin_oe", pin_oe, 0);
    rd(3'd1, 1'b0, 32'h0, 1'b0, "rd_out_after_rst");

    // Three-word configuration: word 3 is out of range, word 2 holds pins 32..39
    acc2(1'b0, 3'd0, 2'd3, '0, 16'h0, 1'b1, "w16_rd_bad_word");
    acc2(1'b1, 3'd0, 2'd2, 16'hFFFF, '0, 1'b0, "w16_wr_dir2");
    chk("w16_pin_oe", pin_oe2, 40'hFF_0000_0000);
    acc2(1'b0, 3'd0, 2'd2, '0, 16'h00FF, 1'b0, "w16_rd_dir2");

    cycles(5);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
